// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle sequencer for a pwm instance: one-shot linear fades or continuous 0<->target breathing.
// state   | meaning
// IDLE    | waiting for a command, duty held
// RAMP    | one-shot fade toward tgt, done pulse on arrival
// BREATHE | triangle sweep between 0 and tgt until stopped
module pwm_fade_ctrl #(
  parameter int CLK_FREQ = 100000000,
  parameter int PWM_FREQ = 20000,
  parameter int WL       = $clog2(CLK_FREQ/PWM_FREQ),
  parameter int STEP_WL  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [WL-1:0]      i_cmd_target,
  input  logic [STEP_WL-1:0] i_cmd_step_div,
  input  logic               i_cmd_breathe,
  input  logic               i_stop,
  output logic [WL-1:0]      o_duty_cycle,
  output logic               o_busy,
  output logic               o_done
);

  localparam int            MAX_DUTY = CLK_FREQ/PWM_FREQ;
  localparam logic [WL-1:0] MAX_W    = WL'(MAX_DUTY);

  typedef enum logic [1:0] {ST_IDLE, ST_RAMP, ST_BREATHE} state_t;

  state_t             state_q, state_d;
  logic [WL-1:0]      duty_q, duty_d;
  logic [WL-1:0]      tgt_q, tgt_d;
  logic [STEP_WL-1:0] div_q, div_d;
  logic [STEP_WL-1:0] cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               done_q, done_d;

  logic [WL-1:0]      tgt_in;
  logic [WL-1:0]      duty_step;
  logic [STEP_WL-1:0] div_eff;
  logic               tick;

  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    tgt_d     = tgt_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    tgt_in    = (i_cmd_target > MAX_W) ? MAX_W : i_cmd_target;
    div_eff   = (div_q == '0) ? STEP_WL'(1) : div_q;
    tick      = (cnt_q == div_eff - STEP_WL'(1));
    duty_step = dir_q ? duty_q + WL'(1) : duty_q - WL'(1);

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (i_cmd_valid) begin
          tgt_d   = tgt_in;
          div_d   = i_cmd_step_div;
          dir_d   = (duty_q < tgt_in);
          state_d = i_cmd_breathe ? ST_BREATHE : ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (i_stop) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (div_q == '0 || duty_q == tgt_q) begin
          // immediate jump, or already sitting on the target at accept
          duty_d  = tgt_q;
          state_d = ST_IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else if (tick) begin
          cnt_d  = '0;
          duty_d = duty_step;
          if (duty_step == tgt_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + STEP_WL'(1);
        end
      end
      ST_BREATHE: begin
        if (i_stop) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (tick) begin
          cnt_d = '0;
          // endpoints reverse and step on the same tick, so the wave never dwells
          if (dir_q) begin
            if (duty_q == tgt_q) begin
              dir_d  = 1'b0;
              duty_d = (duty_q == '0) ? '0 : duty_q - WL'(1);
            end else begin
              duty_d = duty_q + WL'(1);
            end
          end else begin
            if (duty_q == '0) begin
              dir_d  = 1'b1;
              duty_d = (tgt_q == '0) ? '0 : WL'(1);
            end else begin
              duty_d = duty_q - WL'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + STEP_WL'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      tgt_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  assign o_cmd_ready  = (state_q == ST_IDLE);
  assign o_busy       = (state_q != ST_IDLE);
  assign o_done       = done_q;
  assign o_duty_cycle = duty_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Scoreboard bench for pwm_fade_ctrl: commands push per-cycle expectations, a monitor pops and compares.
module tb_pwm_fade_ctrl;
  localparam int WL   = 13;
  localparam int SWL  = 16;
  localparam int MAXD = 5000;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_cmd_valid;
  logic           o_cmd_ready;
  logic [WL-1:0]  i_cmd_target;
  logic [SWL-1:0] i_cmd_step_div;
  logic           i_cmd_breathe;
  logic           i_stop;
  logic [WL-1:0]  o_duty_cycle;
  logic           o_busy;
  logic           o_done;

  pwm_fade_ctrl dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_target(i_cmd_target), .i_cmd_step_div(i_cmd_step_div),
    .i_cmd_breathe(i_cmd_breathe), .i_stop(i_stop),
    .o_duty_cycle(o_duty_cycle), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct { int duty; bit done; bit busy; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int model_duty = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Triangle wave over [0,t] indexed by phase p (0 at bottom, t at top).
  function automatic int tri_wave(int p, int t);
    int m;
    if (t == 0) return 0;
    m = p % (2 * t);
    return (m <= t) ? m : 2 * t - m;
  endfunction

  function automatic int oneshot_val(int s, int t, int div, int k);
    int n, d;
    if (div == 0 || s == t) return (k == 0) ? s : t;
    n = k / div;
    d = (t > s) ? t - s : s - t;
    if (n > d) n = d;
    return (t > s) ? s + n : s - n;
  endfunction

  function automatic int breathe_val(int s, int t, int div, int k);
    int n;
    n = k / ((div == 0) ? 1 : div);
    if (s > t) return (n <= s) ? s - n : tri_wave(n - s, t);
    return tri_wave(s + n, t);
  endfunction

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("duty",  int'(o_duty_cycle), e.duty);
      check("done",  int'(o_done),       int'(e.done));
      check("busy",  int'(o_busy),       int'(e.busy));
      check("ready", int'(o_cmd_ready),  int'(!e.busy));
    end
  end

  // ks_in: 0 = no stop, -1 = random stop edge, else stop edge offset from accept.
  task automatic run_cmd(int traw, int div, bit br, int ks_in, int extra, bit ign, bit stop_acc);
    int s, t, d, kd, busy_end, last, j, ks, kk;
    bit stop_eff, stopped;
    exp_t e;
    s = model_duty;
    t = (traw > MAXD) ? MAXD : traw;
    d = (t > s) ? t - s : s - t;
    kd = br ? 1 << 30 : ((div == 0 || d == 0) ? 1 : div * d);
    ks = ks_in;
    if (ks < 0) ks = br ? $urandom_range(120, 5) : $urandom_range(kd + 2, 1);
    stop_eff = (ks > 0) && (ks <= kd);
    busy_end = stop_eff ? ks : kd;
    last = ((ks > busy_end) ? ks : busy_end) + extra;
    for (int k = 0; k <= last; k++) begin
      stopped = stop_eff && (k >= ks);
      kk = stopped ? ks - 1 : k;
      e.duty = br ? breathe_val(s, t, div, kk) : oneshot_val(s, t, div, kk);
      e.busy = (k < busy_end);
      e.done = !br && !stop_eff && (k == kd);
      sb.push_back(e);
      if (k == last) model_duty = e.duty;
    end
    j = ign ? $urandom_range(busy_end, 1) : -1;
    i_cmd_valid    = 1'b1;
    i_cmd_target   = WL'(traw);
    i_cmd_step_div = SWL'(div);
    i_cmd_breathe  = br;
    i_stop         = stop_acc;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      i_cmd_valid = 1'b0;
      i_stop      = 1'b0;
      if (k + 1 == ks) i_stop = 1'b1;
      if (k + 1 == j) begin
        i_cmd_valid    = 1'b1;
        i_cmd_target   = WL'($urandom_range(8191, 0));
        i_cmd_step_div = SWL'($urandom_range(3, 0));
        i_cmd_breathe  = $urandom_range(1, 0) != 0;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int traw, div, s, t;
    bit br;
    rst = 1'b0;
    i_cmd_valid = 1'b0; i_cmd_target = '0; i_cmd_step_div = '0;
    i_cmd_breathe = 1'b0; i_stop = 1'b0;
    #2;
    check("rst_duty",  int'(o_duty_cycle), 0);
    check("rst_ready", int'(o_cmd_ready),  1);
    check("rst_busy",  int'(o_busy),       0);
    check("rst_done",  int'(o_done),       0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_cmd(10,   3, 0, 0,  2, 0, 0);
    run_cmd(10,   5, 0, 0,  1, 0, 0);
    run_cmd(2,    1, 0, 0,  1, 1, 0);
    run_cmd(4,    1, 1, 10, 2, 0, 0);
    run_cmd(8000, 0, 0, 0,  2, 0, 0);
    run_cmd(7,    0, 0, 0,  1, 0, 1);
    run_cmd(7,    5, 0, 0,  2, 0, 0);
    run_cmd(2,    2, 0, 0,  2, 1, 0);
    run_cmd(0,    1, 1, 6,  1, 0, 0);
    run_cmd(30,   4, 0, 10, 2, 0, 0);
    run_cmd(40,   0, 1, 12, 1, 1, 0);

    for (int n = 0; n < 40; n++) begin
      br  = ($urandom_range(3, 0) == 0);
      div = $urandom_range(4, 0);
      if ($urandom_range(4, 0) == 0) begin
        traw = $urandom_range(8191, 0);
        if (!br) div = 0;
      end else begin
        traw = model_duty + $urandom_range(80, 0) - 40;
        if (traw < 0) traw = 0;
      end
      run_cmd(traw, div, br, (br || $urandom_range(2, 0) == 0) ? -1 : 0,
              $urandom_range(3, 0), $urandom_range(1, 0) != 0, $urandom_range(3, 0) == 0);
    end
    drain();

    s = model_duty;
    t = (s < 2500) ? s + 100 : s - 100;
    @(negedge clk);
    i_cmd_valid = 1'b1; i_cmd_target = WL'(t); i_cmd_step_div = SWL'(2);
    i_cmd_breathe = 1'b0; i_stop = 1'b0;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("pre_rst_duty", int'(o_duty_cycle), oneshot_val(s, t, 2, 7));
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_duty",  int'(o_duty_cycle), 0);
    check("async_rst_ready", int'(o_cmd_ready),  1);
    check("async_rst_busy",  int'(o_busy),       0);
    check("async_rst_done",  int'(o_done),       0);
    @(negedge clk);
    rst = 1'b1;
    model_duty = 0;
    @(negedge clk);
    run_cmd(5, 1, 0, 0, 2, 0, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
